// File: rtl/imem_fetch_load_ctrl.sv
// Fetch-PC sequencer and arbiter for the instruction memory's single port.
// The IF stage fetches in RUN; a loader word is written one cell per cycle in LOAD.
module imem_fetch_load_ctrl #(
    parameter int WORD_LEN       = 16,
    parameter int CELL_SIZE      = 4,
    parameter int CELLS_PER_WORD = 4,
    parameter int MEM_SIZE       = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        freeze,
    input  logic                        br_taken,
    input  logic [WORD_LEN-1:0]         br_addr,
    input  logic                        ld_req,
    input  logic [WORD_LEN-1:0]         ld_addr,
    input  logic [WORD_LEN-1:0]         ld_data,
    output logic [WORD_LEN-1:0]         pc,
    output logic                        fetch_valid,
    output logic                        busy,
    output logic                        ld_ack,
    output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
    output logic                        mem_we,
    output logic [CELL_SIZE-1:0]        mem_wdata,
    output logic [1:0]                  dbg_state
);
    localparam int AW = $clog2(MEM_SIZE);
    localparam int CW = $clog2(CELLS_PER_WORD);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [AW-1:0]       pc_q;
    logic [AW-1:0]       base_q;
    logic [AW-1:0]       pend_addr_q;
    logic                pend_q;
    logic [CW-1:0]       cnt_q;
    logic [WORD_LEN-1:0] word_q;
    logic [WORD_LEN-1:0] word_sh;

    // Port handshake: ld_req is a level; it is accepted only in RUN, and the word is
    // complete when ld_ack pulses for one cycle. Redirects arriving while busy are
    // held as a pending target and applied when leaving DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc_q        <= '0;
            base_q      <= '0;
            pend_addr_q <= '0;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            word_q      <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ld_req) begin
                        base_q <= {ld_addr[AW-1:CW], {CW{1'b0}}};
                        word_q <= ld_data;
                        cnt_q  <= '0;
                        state  <= LOAD;
                        if (br_taken) begin
                            pend_q      <= 1'b1;
                            pend_addr_q <= br_addr[AW-1:0];
                        end
                    end else if (br_taken) begin
                        pc_q <= br_addr[AW-1:0];
                    end else if (!freeze) begin
                        pc_q <= pc_q + AW'(CELLS_PER_WORD);
                    end
                end
                LOAD: begin
                    if (br_taken) begin
                        pend_q      <= 1'b1;
                        pend_addr_q <= br_addr[AW-1:0];
                    end
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(CELLS_PER_WORD - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state  <= RUN;
                    pend_q <= 1'b0;
                    // A redirect seen in this very cycle is the most recent one.
                    if (br_taken) begin
                        pc_q <= br_addr[AW-1:0];
                    end else if (pend_q) begin
                        pc_q <= pend_addr_q;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Most-significant cell goes to the lowest address.
    always_comb begin
        word_sh = word_q << (32'(cnt_q) * CELL_SIZE);
    end

    always_comb begin
        mem_addr  = pc_q;
        mem_we    = 1'b0;
        mem_wdata = '0;
        busy      = 1'b0;
        ld_ack    = 1'b0;
        case (state)
            LOAD: begin
                mem_addr  = base_q + {{(AW-CW){1'b0}}, cnt_q};
                mem_we    = 1'b1;
                mem_wdata = word_sh[WORD_LEN-1 -: CELL_SIZE];
                busy      = 1'b1;
            end
            DONE: begin
                busy   = 1'b1;
                ld_ack = 1'b1;
            end
            default: ;
        endcase
    end

    assign fetch_valid = !rst && (state == RUN) && !freeze && !ld_req;
    assign pc          = {{(WORD_LEN-AW){1'b0}}, pc_q};
    assign dbg_state   = state;

    logic unused_bits;
    assign unused_bits = ^{ld_addr[WORD_LEN-1:AW], ld_addr[CW-1:0],
                           br_addr[WORD_LEN-1:AW], word_sh[WORD_LEN-CELL_SIZE-1:0]};
endmodule

// File: tb/tb_imem_fetch_load_ctrl.sv
// Bench for imem_fetch_load_ctrl: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level model of the fetch/load rules.
module tb_imem_fetch_load_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        br_taken;
    logic [15:0] br_addr;
    logic        ld_req;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic [15:0] pc;
    logic        fetch_valid;
    logic        busy;
    logic        ld_ack;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wdata;
    logic [1:0]  dbg_state;

    imem_fetch_load_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .br_taken   (br_taken),
        .br_addr    (br_addr),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .pc         (pc),
        .fetch_valid(fetch_valid),
        .busy       (busy),
        .ld_ack     (ld_ack),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // Memory image built from the port's write strobes.
    logic [3:0] tb_mem [256];
    always @(posedge clk) begin
        if (mem_we === 1'b1) tb_mem[mem_addr] <= mem_wdata;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending cell writes as {addr, data}, a DONE flag, the PC
    // and a pending redirect target.
    logic [11:0] exp_q[$];
    bit          m_done;
    logic [7:0]  m_pc;
    bit          m_pend;
    logic [7:0]  m_pend_addr;

    task automatic model_reset();
        exp_q.delete();
        m_done = 0;
        m_pc   = 8'h00;
        m_pend = 0;
    endtask

    task automatic cycle();
        logic [11:0] w;
        logic [7:0]  base;
        @(negedge clk);
        if (rst) begin
            check_eq("fv_in_reset", fetch_valid, 0);
        end else if (exp_q.size() > 0) begin
            w = exp_q[0];
            check_eq("load_we", mem_we, 1);
            check_eq("load_addr", mem_addr, w[11:4]);
            check_eq("load_wdata", mem_wdata, w[3:0]);
            check_eq("load_busy", busy, 1);
            check_eq("load_ack", ld_ack, 0);
            check_eq("load_fv", fetch_valid, 0);
            check_eq("load_pc", pc, m_pc);
        end else if (m_done) begin
            check_eq("done_we", mem_we, 0);
            check_eq("done_ack", ld_ack, 1);
            check_eq("done_busy", busy, 1);
            check_eq("done_fv", fetch_valid, 0);
            check_eq("done_pc", pc, m_pc);
        end else begin
            check_eq("run_we", mem_we, 0);
            check_eq("run_ack", ld_ack, 0);
            check_eq("run_busy", busy, 0);
            check_eq("run_addr", mem_addr, m_pc);
            check_eq("run_fv", fetch_valid, !freeze && !ld_req);
            check_eq("run_pc", pc, m_pc);
        end

        if (rst) begin
            model_reset();
        end else if (exp_q.size() > 0) begin
            if (br_taken) begin
                m_pend      = 1;
                m_pend_addr = br_addr[7:0];
            end
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_done = 1;
        end else if (m_done) begin
            if (br_taken) m_pc = br_addr[7:0];
            else if (m_pend) m_pc = m_pend_addr;
            m_pend = 0;
            m_done = 0;
        end else if (ld_req) begin
            base = ld_addr[7:0] & 8'hFC;
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back({8'(base + 8'(i)), 4'((ld_data >> (12 - 4 * i)) & 16'hF)});
            end
            if (br_taken) begin
                m_pend      = 1;
                m_pend_addr = br_addr[7:0];
            end
        end else if (br_taken) begin
            m_pc = br_addr[7:0];
        end else if (!freeze) begin
            m_pc = m_pc + 8'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        freeze   = 0;
        br_taken = 0;
        br_addr  = '0;
        ld_req   = 0;
        ld_addr  = '0;
        ld_data  = '0;
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 256; i++) tb_mem[i] = 4'h0;
        idle_inputs();
        model_reset();
        rst = 1;
        repeat (2) cycle();
        rst = 0;

        // Idle fetch stream after reset.
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_pc_seq", pc, 16'(4 * i));
            cycle();
        end

        // Freeze, then a redirect while frozen.
        br_taken = 1; br_addr = 16'h0008;
        cycle();
        br_taken = 0;
        freeze = 1;
        cycle();
        check_eq("t2_pc_frozen", pc, 16'h0008);
        br_taken = 1; br_addr = 16'h0040;
        cycle();
        idle_inputs();
        check_eq("t2_pc_redirect", pc, 16'h0040);
        cycle();
        check_eq("t2_pc_next", pc, 16'h0044);

        // Load one word, checking ack latency and the resulting cells.
        ld_req = 1; ld_addr = 16'h000E; ld_data = 16'h3201;
        cycle();
        ld_req = 0; ld_addr = 16'hFFFF; ld_data = 16'hFFFF;
        lat = 1;
        while (ld_ack !== 1'b1 && lat < 12) begin
            cycle();
            lat++;
        end
        check_eq("t3_ack_latency", lat, 5);
        cycle();
        check_eq("t3_pc_kept", pc, 16'h0044);
        check_eq("t3_cell_0c", tb_mem[8'h0C], 4'h3);
        check_eq("t3_cell_0d", tb_mem[8'h0D], 4'h2);
        check_eq("t3_cell_0e", tb_mem[8'h0E], 4'h0);
        check_eq("t3_cell_0f", tb_mem[8'h0F], 4'h1);
        idle_inputs();

        // Redirect arriving mid-load is deferred until the load completes.
        ld_req = 1; ld_addr = 16'h0031; ld_data = 16'h9C5E;
        cycle();
        idle_inputs();
        cycle();
        br_taken = 1; br_addr = 16'h0020;
        cycle();
        br_taken = 0;
        repeat (3) cycle();
        check_eq("t4_pc_pending", pc, 16'h0020);
        check_eq("t4_cell_30", tb_mem[8'h30], 4'h9);
        check_eq("t4_cell_33", tb_mem[8'h33], 4'hE);

        // PC and load address wrap at the top of memory.
        br_taken = 1; br_addr = 16'h00FC;
        cycle();
        br_taken = 0;
        check_eq("t5_pc_fc", pc, 16'h00FC);
        cycle();
        check_eq("t5_pc_wrap", pc, 16'h0000);
        ld_req = 1; ld_addr = 16'h00FE; ld_data = 16'hABCD;
        cycle();
        idle_inputs();
        repeat (5) cycle();
        check_eq("t5_cell_fc", tb_mem[8'hFC], 4'hA);
        check_eq("t5_cell_ff", tb_mem[8'hFF], 4'hD);

        // Reset in the third write cycle aborts the load.
        ld_req = 1; ld_addr = 16'h0050; ld_data = 16'h1234;
        cycle();
        idle_inputs();
        repeat (2) cycle();
        rst = 1;
        cycle();
        rst = 0;
        check_eq("t6_we_after_rst", mem_we, 0);
        check_eq("t6_ack_after_rst", ld_ack, 0);
        check_eq("t6_pc_after_rst", pc, 16'h0000);
        check_eq("t6_state_run", dbg_state, 2'd0);
        check_eq("t6_cell_53_untouched", tb_mem[8'h53], 4'h0);
        repeat (6) cycle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            freeze   = ($urandom_range(0, 99) < 20);
            br_taken = ($urandom_range(0, 99) < 15);
            br_addr  = 16'($urandom_range(0, 255));
            ld_req   = ($urandom_range(0, 99) < 10);
            ld_addr  = 16'($urandom);
            ld_data  = 16'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
